// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared constants and the divisor clamp helper for clk_div_n.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int DIV_MIN = 2;

  // Divisors of 0 or 1 cannot form a period with a high and a low phase.
  function automatic logic [31:0] div_clamp(input logic [31:0] value);
    return (value < 32'(DIV_MIN)) ? 32'(DIV_MIN) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_n_if.sv
// ============================================================================
// Module   : clk_div_n_if
// Purpose  : Control/status bundle of the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_div_n_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] div;
  logic             fout;
  logic             tick;
  logic             busy;

  modport master (
    output en, load, div,
    input  fout, tick, busy
  );

  modport slave (
    input  en, load, div,
    output fout, tick, busy
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_neg_ext.sv
// ============================================================================
// Module   : clk_div_neg_ext
// Purpose  : Negedge half-cycle extender that stretches the high phase of an
//            odd divisor by half an input period (50% duty).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_neg_ext (
  input  wire logic fin,
  input  wire logic rst,
  input  wire logic pos,
  input  wire logic odd,
  output logic      neg
);

  logic neg_d;
  logic neg_q;

  always_comb begin
    neg_d = pos & odd;
  end

  always_ff @(negedge fin or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign neg = neg_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_n.sv
// ============================================================================
// Module   : clk_div_n
// Purpose  : Programmable integer clock divider with glitch-free divisor
//            changes at period boundaries. Optional 50% duty for odd
//            divisors via macro CLK_DIV_ODD_DUTY50_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 4
) (
  input  wire logic  fin,
  input  wire logic  rst,
  clk_div_n_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             run_q, run_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] div_clamped;
  logic             wrap;
  logic             apply;

  always_comb begin
    div_clamped  = CNT_W'(div_clamp(32'(bus.div)));
    wrap         = run_q && (cnt_q == (cur_q - CNT_W'(1)));
    // Divisor may change on a wrap, on the first enabled edge, or while idle.
    apply        = !bus.en || !run_q || wrap;

    cnt_d        = cnt_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    run_d        = run_q;
    pos_d        = pos_q;
    tick_d       = tick_q;

    if (apply) begin
      if (bus.load) begin
        cur_d = div_clamped;
      end else if (pend_valid_q) begin
        cur_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_d       = div_clamped;
      pend_valid_d = 1'b1;
    end

    if (bus.en) begin
      run_d  = 1'b1;
      cnt_d  = (run_q && !wrap) ? (cnt_q + CNT_W'(1)) : '0;
      tick_d = (cnt_d == '0);
      pos_d  = (cnt_d < (cur_d >> 1));
    end else begin
      run_d  = 1'b0;
      cnt_d  = '0;
      tick_d = 1'b0;
      pos_d  = 1'b0;
    end
  end

  always_ff @(posedge fin or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      cur_q        <= CNT_W'(DIV_RST);
      pend_q       <= CNT_W'(DIV_RST);
      pend_valid_q <= 1'b0;
      run_q        <= 1'b0;
      pos_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      run_q        <= run_d;
      pos_q        <= pos_d;
      tick_q       <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg;

  clk_div_neg_ext u_neg_ext (
    .fin (fin),
    .rst (rst),
    .pos (pos_q),
    .odd (cur_q[0]),
    .neg (neg)
  );

  assign bus.fout = pos_q | neg;
`else
  assign bus.fout = pos_q;
`endif

  assign bus.tick = tick_q;
  assign bus.busy = pend_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_n.sv
// ============================================================================
// Module   : tb_clk_div_n
// Purpose  : Self-checking bench for clk_div_n against a period-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_n;

  localparam int HALF = 10;

  logic fin;
  logic rst;
  int   total;
  int   bad;

  clk_div_n_if #(.CNT_W(8)) bus ();

  clk_div_n #(.CNT_W(8), .DIV_RST(4)) dut (
    .fin (fin),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    fin = 1'b0;
    forever #(HALF) fin = ~fin;
  end

  realtime last_rise, prev_rise, last_fall;
  always @(posedge bus.fout) begin
    prev_rise <= last_rise;
    last_rise <= $realtime;
  end
  always @(negedge bus.fout) last_fall <= $realtime;

  // Model: each period is laid out as a queue of per-cycle (fout, tick) values.
  bit qpos[$];
  bit qtick[$];
  int m_d, m_pend, m_idx;
  bit m_pv, e_pos, e_tick, e_busy, e_fout;
`ifdef CLK_DIV_ODD_DUTY50_EN
  bit prev_pos, prev_odd;
`endif

  function automatic int exp_high(int d);
`ifdef CLK_DIV_ODD_DUTY50_EN
    if (d % 2 == 1) return d * HALF;
`endif
    return (d / 2) * 2 * HALF;
  endfunction

  task automatic model_reset();
    qpos.delete();
    qtick.delete();
    m_d = 4; m_pend = 4; m_idx = 0; m_pv = 0;
    e_pos = 0; e_tick = 0; e_busy = 0; e_fout = 0;
`ifdef CLK_DIV_ODD_DUTY50_EN
    prev_pos = 0; prev_odd = 0;
`endif
  endtask

  task automatic next_edge();
    int cl;
    @(posedge fin);
    if (rst) begin
`ifdef CLK_DIV_ODD_DUTY50_EN
      prev_pos = e_pos;
      prev_odd = (m_d % 2) == 1;
`endif
      cl = (int'(bus.div) < 2) ? 2 : int'(bus.div);
      if (!bus.en) begin
        qpos.delete(); qtick.delete();
        if (bus.load) m_d = cl;
        else if (m_pv) m_d = m_pend;
        m_pv = 0; e_pos = 0; e_tick = 0; m_idx = 0;
      end else begin
        if (qpos.size() == 0) begin
          if (bus.load) m_d = cl;
          else if (m_pv) m_d = m_pend;
          m_pv = 0;
          for (int i = 0; i < m_d; i++) begin
            qpos.push_back(i < m_d / 2);
            qtick.push_back(i == 0);
          end
          m_idx = 0;
        end else begin
          m_idx++;
          if (bus.load) begin m_pend = cl; m_pv = 1; end
        end
        e_pos  = qpos.pop_front();
        e_tick = qtick.pop_front();
      end
      e_busy = m_pv;
`ifdef CLK_DIV_ODD_DUTY50_EN
      e_fout = e_pos | (prev_pos & prev_odd);
`else
      e_fout = e_pos;
`endif
    end
    #1;
  endtask

  task automatic wait_idx(int target, string name);
    int k;
    for (k = 0; k < 64 && m_idx != target; k++) next_edge();
    if (m_idx != target) begin
      total++; bad++;
      $display("FAIL %s timeout waiting idx got %0d want %0d", name, m_idx, target);
    end
  endtask

  task automatic pulse_load(int value);
    bus.div  = 8'(value);
    bus.load = 1'b1;
    next_edge();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.fout, bus.tick, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL reset_hold fout/tick/busy got %b%b%b want 000", bus.fout, bus.tick, bus.busy);
    end
    #5 rst = 1'b1;
    next_edge();
    total++;
    if ({bus.fout, bus.tick, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL reset_idle fout/tick/busy got %b%b%b want 000", bus.fout, bus.tick, bus.busy);
    end
  endtask

  task automatic test_div4();
    bus.en = 1'b1;
    next_edge();
    total++;
    if ({bus.fout, bus.tick} !== 2'b11) begin
      bad++; $display("FAIL div4_first fout/tick got %b%b want 11", bus.fout, bus.tick);
    end
    for (int c = 0; c < 12; c++) begin
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL div4 cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    wait_idx(3, "div4");
    total++;
    if (last_rise - prev_rise != real'(8 * HALF) || last_fall - last_rise != real'(exp_high(4))) begin
      bad++; $display("FAIL div4_duty period %0t high %0t want %0d %0d", last_rise - prev_rise, last_fall - last_rise, 8 * HALF, exp_high(4));
    end
  endtask

  task automatic test_odd5();
    pulse_load(5);
    for (int c = 0; c < 15; c++) begin
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL odd5 cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    wait_idx(4, "odd5");
    total++;
    if (last_rise - prev_rise != real'(10 * HALF) || last_fall - last_rise != real'(exp_high(5))) begin
      bad++; $display("FAIL odd5_duty period %0t high %0t want %0d %0d", last_rise - prev_rise, last_fall - last_rise, 10 * HALF, exp_high(5));
    end
  endtask

  task automatic test_pending();
    pulse_load(4);
    repeat (12) next_edge();
    wait_idx(1, "pending");
    pulse_load(6);
    total++;
    if (bus.busy !== 1'b1 || e_busy !== 1'b1) begin
      bad++; $display("FAIL pending_busy got %b want 1", bus.busy);
    end
    for (int c = 0; c < 16; c++) begin
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL pending cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    wait_idx(5, "pending");
    total++;
    if (last_rise - prev_rise != real'(12 * HALF) || bus.busy !== 1'b0) begin
      bad++; $display("FAIL pending_period period %0t busy %b want %0d 0", last_rise - prev_rise, bus.busy, 12 * HALF);
    end
  endtask

  task automatic test_clamp();
    for (int v = 0; v < 2; v++) begin
      pulse_load(v);
      for (int c = 0; c < 10; c++) begin
        next_edge();
        total++;
        if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
          bad++; $display("FAIL clamp%0d cyc%0d got %b%b%b want %b%b%b", v, c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
        end
      end
      wait_idx(1, "clamp");
      total++;
      if (last_rise - prev_rise != real'(4 * HALF) || last_fall - last_rise != real'(2 * HALF)) begin
        bad++; $display("FAIL clamp%0d_duty period %0t high %0t want %0d %0d", v, last_rise - prev_rise, last_fall - last_rise, 4 * HALF, 2 * HALF);
      end
    end
  endtask

  task automatic test_load_at_wrap();
    pulse_load(4);
    repeat (12) next_edge();
    wait_idx(3, "wrap");
    pulse_load(3);
    for (int c = 0; c < 9; c++) begin
      total++;
      if (bus.busy !== 1'b0 || {bus.fout, bus.tick} !== {e_fout, e_tick}) begin
        bad++; $display("FAIL wrap cyc%0d fout/tick/busy got %b%b%b want %b%b0", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick);
      end
      next_edge();
    end
    wait_idx(2, "wrap");
    total++;
    if (last_rise - prev_rise != real'(6 * HALF) || last_fall - last_rise != real'(exp_high(3))) begin
      bad++; $display("FAIL wrap_duty period %0t high %0t want %0d %0d", last_rise - prev_rise, last_fall - last_rise, 6 * HALF, exp_high(3));
    end
  endtask

  task automatic test_back_to_back();
    wait_idx(0, "b2b");
    pulse_load(7);
    pulse_load(9);
    for (int c = 0; c < 30; c++) begin
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL b2b cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    wait_idx(8, "b2b");
    total++;
    if (last_rise - prev_rise != real'(18 * HALF)) begin
      bad++; $display("FAIL b2b_period got %0t want %0d", last_rise - prev_rise, 18 * HALF);
    end
  endtask

  task automatic test_en_toggle();
    wait_idx(1, "en");
    bus.en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_edge();
      total++;
      if (bus.tick !== 1'b0 || bus.fout !== e_fout || (c > 0 && bus.fout !== 1'b0)) begin
        bad++; $display("FAIL en_off cyc%0d fout/tick got %b%b want %b0", c, bus.fout, bus.tick, e_fout);
      end
    end
    bus.en = 1'b1;
    next_edge();
    total++;
    if ({bus.fout, bus.tick} !== 2'b11) begin
      bad++; $display("FAIL en_on fout/tick got %b%b want 11", bus.fout, bus.tick);
    end
  endtask

  task automatic test_reset_mid();
    wait_idx(0, "rstmid");
    pulse_load(6);
    #3 rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.fout, bus.tick, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL rstmid fout/tick/busy got %b%b%b want 000", bus.fout, bus.tick, bus.busy);
    end
    #5 rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL rstmid cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    wait_idx(3, "rstmid");
    total++;
    if (last_rise - prev_rise != real'(8 * HALF)) begin
      bad++; $display("FAIL rstmid_period got %0t want %0d", last_rise - prev_rise, 8 * HALF);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bus.en   = ($urandom_range(0, 29) != 0);
      bus.load = ($urandom_range(0, 7) == 0);
      bus.div  = 8'($urandom_range(0, 11));
      next_edge();
      total++;
      if ({bus.fout, bus.tick, bus.busy} !== {e_fout, e_tick, e_busy}) begin
        bad++; $display("FAIL random cyc%0d got %b%b%b want %b%b%b", c, bus.fout, bus.tick, bus.busy, e_fout, e_tick, e_busy);
      end
    end
    bus.load = 1'b0;
    bus.en   = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    last_rise = 0; prev_rise = 0; last_fall = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.div = '0;
    model_reset();
    #20;
    test_reset();
    test_div4();
    test_odd5();
    test_pending();
    test_clamp();
    test_load_at_wrap();
    test_back_to_back();
    test_en_toggle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_n.md
# clk_div_n

Programmable integer clock divider, the parametrised successor to the fixed divide-by-4 stage. Divides `fin` by a run-time divisor D (2..2^CNT_W-1) and produces a square-ish output `fout` plus a one-cycle `tick` strobe. Divisor changes are glitch-free: they take effect only at a period boundary. It sits in the clock-generation area, feeding slow-clock and enable domains.

## Interface
- CNT_W, 8, width of divisor and internal counter
- DIV_RST, 4, divisor in force after reset (must be ≥2)
- fin  in  1  input clock; all state on posedge, plus negedge stage when the macro is set
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- en  in  1  run enable, sampled on posedge fin
- div  in  CNT_W  requested divisor, sampled only when `load`=1
- load  in  1  one-cycle strobe: capture `div` as pending divisor
- fout  out  1  divided clock
- tick  out  1  high for one fin cycle at each fout rising edge
- busy  out  1  a pending divisor is waiting for the period boundary

## Operation
- Reset (rst=0, async): cnt=0, cur_D=DIV_RST, pend_valid=0, fout=0, tick=0, busy=0.
- Clamp: any captured `div` value of 0 or 1 is stored as 2.
- Counter: while en=1, cnt counts 0..cur_D-1 and wraps to 0. The wrap edge is the period boundary.
- Output (posedge part): pos_r is registered 1 when the next cnt is < (cur_D>>1), else 0.
  - Even D: high D/2 cycles, low D/2 cycles.
  - Odd D, macro off: high (D-1)/2 cycles, low (D+1)/2 cycles.
- tick=1 in exactly the cycles where cnt==0 and en=1.
- Load:
  - `load`=1 writes clamp(div) into pend and sets pend_valid=1; busy mirrors pend_valid.
  - At the next period boundary, cur_D←pend and pend_valid←0.
  - A second load before the boundary overwrites pend; the last value wins.
- Load in the wrap cycle itself (cnt==cur_D-1, en=1): the new divisor governs the period that starts at that edge. pend_valid stays 0.
- en=0: cnt←0 and pos_r←0 on the next edge, so fout goes low and tick=0. Any pending divisor is applied immediately, so busy clears.
- en 0→1: the first enabled edge gives cnt=0, fout=1 and tick=1.
- Reset mid-period: all state returns to reset values immediately. A pending divisor is discarded.

## Timing
- Latency: from en sampled high to fout rising is one fin edge (same edge).
- Period: exactly cur_D fin cycles, with no runt or stretched pulse at any divisor change.
- Divisor-change latency: between 1 and cur_D edges after `load`.
- All outputs are registered. There is no combinational path from inputs to outputs, except the fout OR term when the macro is set (see Configuration).

## Configuration
- `CLK_DIV_ODD_DUTY50_EN` defined:
  - Adds a negedge flop neg_r ← pos_r.
  - For odd cur_D, fout = pos_r | neg_r, giving exactly 50% duty (high D/2 fin periods).
  - For even cur_D, neg_r is forced to 0.
  - neg_r resets to 0 asynchronously with rst.
- Not defined: no negedge logic; fout = pos_r, with the odd-D duty described in Operation.

## Structure
- Package `clk_div_pkg`:
  - DIV_MIN=2
  - Clamp function `div_clamp(value)`
- Sub-module `clk_div_neg_ext` (negedge half-cycle extender), instantiated only under the macro.
- All other logic lives in `clk_div_n`.

## Test plan
- fin period 20 ns, rst low 0–30 ns then high, en=1, D=4 → fout period 80 ns, high 40 ns; tick 20 ns wide every 80 ns.
- D=5 loaded, macro off → fout high 40 ns, low 60 ns. Macro on → high 50 ns, low 50 ns; period 100 ns in both cases.
- During D=4, load div=6 at cnt=1 → busy=1. Current period completes at 80 ns, the next period is 120 ns, busy clears at the wrap.
- Load div=0, then div=1 in separate runs → both behave as D=2 (period 40 ns).
- Load div=3 in the cycle cnt==3 (wrap) → the very next period is 60 ns; busy never asserts.
- rst pulled low mid-high-phase with a pending load → fout=0, tick=0, busy=0 immediately. After release, D=DIV_RST=4 and the pending value is lost. en dropped mid-period → fout low next edge; en restored → fout high on the first edge.
